spi_stream_arbiter: RTL and testbench

- Shares one spi_master_controller stream port (tx/rx valid-ready streams plus eot) between NUM_REQ requesters, e.g. the APB register file and a DMA/boot-loader engine.
- Round-robin grant is held for one whole SPI transaction, ending at the controller's eot pulse. Each rx word is routed back to the granted requester.
- A pending-word counter prevents grant hand-over while rx words are still owed.

---
 rtl/spi_stream_arbiter_if.sv | 34 +++
 rtl/spi_stream_arbiter.sv | 90 +++++++++
 tb/tb_spi_stream_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_stream_arbiter_if.sv
// spi_stream_arbiter_if: stream bundle between NUM_REQ requesters, the arbiter and one SPI controller
// slave modport  : arbiter view (requester tx/rx streams, controller stream port, eot, status)
// master modport : surrounding requesters and controller view of the same wires
interface spi_stream_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ*DATA_W-1:0] req_tx_data_i;
    logic [NUM_REQ-1:0]        req_tx_vld_i;
    logic [NUM_REQ-1:0]        req_tx_rdy_o;
    logic [DATA_W-1:0]         req_rx_data_o;
    logic [NUM_REQ-1:0]        req_rx_vld_o;
    logic [NUM_REQ-1:0]        req_rx_rdy_i;
    logic [DATA_W-1:0]         m_tx_data_o;
    logic                      m_tx_vld_o;
    logic                      m_tx_rdy_i;
    logic [DATA_W-1:0]         m_rx_data_i;
    logic                      m_rx_vld_i;
    logic                      m_rx_rdy_o;
    logic                      eot_i;
    logic [NUM_REQ-1:0]        grant_o;
    logic                      busy_o;
    logic                      err_o;
    modport slave (
        input  req_tx_data_i, req_tx_vld_i, req_rx_rdy_i, m_tx_rdy_i, m_rx_data_i, m_rx_vld_i, eot_i,
        output req_tx_rdy_o, req_rx_data_o, req_rx_vld_o, m_tx_data_o, m_tx_vld_o, m_rx_rdy_o,
               grant_o, busy_o, err_o
    );
    modport master (
        output req_tx_data_i, req_tx_vld_i, req_rx_rdy_i, m_tx_rdy_i, m_rx_data_i, m_rx_vld_i, eot_i,
        input  req_tx_rdy_o, req_rx_data_o, req_rx_vld_o, m_tx_data_o, m_tx_vld_o, m_rx_rdy_o,
               grant_o, busy_o, err_o
    );
endinterface

// File: rtl/spi_stream_arbiter.sv
// spi_stream_arbiter: round-robin share of one SPI controller stream port, grant held per transaction
// clk_i   : clock
// rst_n_i : asynchronous active-low reset
// bus     : requester tx/rx streams, controller tx/rx streams, eot, grant/busy/err status
module spi_stream_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    spi_stream_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_PEND + 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;
    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d, last_q, last_d, pick, cand;
    logic [PW-1:0]      pend_q, pend_d;
    logic               busy_q, busy_d, err_q, err_d;
    logic               found, routed, room, tx_hs, rx_hs;
    // first valid requester strictly after the previous owner, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % NUM_REQ);
            if (!found && bus.req_tx_vld_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end
    // tx is only open in ACTIVE and below the pending limit; rx keeps flowing through DRAIN
    always_comb begin
        routed            = state_q != IDLE;
        room              = pend_q < PW'(MAX_PEND);
        bus.m_tx_vld_o    = state_q == ACTIVE && bus.req_tx_vld_i[gidx_q] && room;
        bus.req_tx_rdy_o  = (state_q == ACTIVE && bus.m_tx_rdy_i && room) ? NUM_REQ'(1) << gidx_q : '0;
        bus.req_rx_vld_o  = (routed && bus.m_rx_vld_i) ? NUM_REQ'(1) << gidx_q : '0;
        bus.m_rx_rdy_o    = routed && bus.req_rx_rdy_i[gidx_q];
        bus.m_tx_data_o   = routed ? bus.req_tx_data_i[gidx_q*DATA_W +: DATA_W] : '0;
        bus.req_rx_data_o = bus.m_rx_data_i;
        tx_hs             = bus.m_tx_vld_o && bus.m_tx_rdy_i;
        rx_hs             = bus.m_rx_vld_i && bus.m_rx_rdy_o;
    end
    // an rx word with nothing owed is flagged and never underflows the counter
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        pend_d  = pend_q + PW'(tx_hs) - PW'(rx_hs && pend_q != '0);
        err_d   = err_q | (rx_hs && pend_q == '0);
        if (state_q == IDLE && found) begin
            state_d = ACTIVE;
            grant_d = NUM_REQ'(1) << pick;
            gidx_d  = pick;
        end else if ((state_q == ACTIVE && bus.eot_i) || (state_q == DRAIN && pend_d == '0)) begin
            state_d = pend_d == '0 ? IDLE : DRAIN;
            grant_d = pend_d == '0 ? '0 : grant_q;
            last_d  = gidx_q;
        end
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            pend_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end
    assign bus.grant_o = grant_q;
    assign bus.busy_o  = busy_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_spi_stream_arbiter.sv
// tb_spi_stream_arbiter: directed scenarios for spi_stream_arbiter with hand-computed expectations
module tb_spi_stream_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int MP = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    spi_stream_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
    spi_stream_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_PEND(MP)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        bus.req_tx_data_i = '0;
        bus.req_tx_vld_i  = '0;
        bus.req_rx_rdy_i  = 2'b11;
        bus.m_tx_rdy_i    = 1'b0;
        bus.m_rx_data_i   = '0;
        bus.m_rx_vld_i    = 1'b0;
        bus.eot_i         = 1'b0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
    endtask
    task automatic test_reset();
        logic [9:0] obs;
        rst_n = 1'b0;
        idle_inputs();
        bus.req_tx_vld_i = 2'b11;
        bus.m_tx_rdy_i   = 1'b1;
        bus.m_rx_vld_i   = 1'b1;
        tick();
        tick();
        obs = {bus.grant_o, bus.busy_o, bus.err_o, bus.m_tx_vld_o, bus.req_tx_rdy_o, bus.m_rx_rdy_o, bus.req_rx_vld_o};
        n_chk++;
        if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_outputs: got %b exp %b", obs, 10'b0); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_idle_grant: got %b exp 00", bus.grant_o); end
    endtask
    task automatic test_basic();
        do_reset();
        bus.req_tx_data_i[31:0] = 32'hA5A5_0001;
        bus.req_tx_vld_i = 2'b01;
        #1;
        n_chk++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL basic_latency: got %b exp 00", bus.grant_o); end
        tick();
        n_chk++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL basic_grant: got %b exp 01", bus.grant_o); end
        n_chk++;
        if (bus.m_tx_data_o !== 32'hA5A5_0001) begin n_fail++; $display("FAIL basic_tx_data: got %h exp a5a50001", bus.m_tx_data_o); end
        n_chk++;
        if (bus.m_tx_vld_o !== 1'b1) begin n_fail++; $display("FAIL basic_tx_vld: got %b exp 1", bus.m_tx_vld_o); end
        bus.m_tx_rdy_i = 1'b1;
        #1;
        n_chk++;
        if (bus.req_tx_rdy_o !== 2'b01) begin n_fail++; $display("FAIL basic_tx_rdy: got %b exp 01", bus.req_tx_rdy_o); end
        tick();
        bus.req_tx_vld_i = 2'b00;
        bus.m_tx_rdy_i   = 1'b0;
        bus.m_rx_vld_i   = 1'b1;
        bus.m_rx_data_i  = 32'h1234_5678;
        #1;
        n_chk++;
        if (bus.req_rx_vld_o !== 2'b01) begin n_fail++; $display("FAIL basic_rx_vld: got %b exp 01", bus.req_rx_vld_o); end
        n_chk++;
        if (bus.req_rx_data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_rx_data: got %h exp 12345678", bus.req_rx_data_o); end
        tick();
        bus.m_rx_vld_i = 1'b0;
        bus.eot_i      = 1'b1;
        tick();
        bus.eot_i = 1'b0;
        n_chk++;
        if ({bus.grant_o, bus.busy_o, bus.err_o} !== 4'b0000) begin n_fail++; $display("FAIL basic_eot_idle: got %b exp 0000", {bus.grant_o, bus.busy_o, bus.err_o}); end
    endtask
    task automatic test_round_robin();
        int idle;
        logic [1:0] exp_g;
        do_reset();
        bus.req_tx_vld_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            idle = 0;
            while (bus.grant_o === 2'b00 && idle < 5) begin
                idle++;
                tick();
            end
            n_chk++;
            if (bus.grant_o !== exp_g) begin n_fail++; $display("FAIL rr_grant_%0d: got %b exp %b", t, bus.grant_o, exp_g); end
            n_chk++;
            if (idle < 1) begin n_fail++; $display("FAIL rr_idle_gap_%0d: got %0d exp >=1", t, idle); end
            bus.eot_i = 1'b1;
            tick();
            bus.eot_i = 1'b0;
        end
        bus.req_tx_vld_i = 2'b00;
    endtask
    task automatic test_max_pend();
        int acc;
        do_reset();
        bus.req_tx_data_i[31:0] = 32'h0000_00C3;
        bus.req_tx_vld_i = 2'b01;
        bus.m_tx_rdy_i   = 1'b1;
        tick();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.m_tx_vld_o && bus.m_tx_rdy_i) acc++;
            tick();
        end
        n_chk++;
        if (acc !== 4) begin n_fail++; $display("FAIL pend_accepted: got %0d exp 4", acc); end
        n_chk++;
        if ({bus.m_tx_vld_o, bus.req_tx_rdy_o} !== 3'b000) begin n_fail++; $display("FAIL pend_blocked: got %b exp 000", {bus.m_tx_vld_o, bus.req_tx_rdy_o}); end
        bus.m_rx_vld_i = 1'b1;
        #1;
        n_chk++;
        if (bus.m_rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL pend_rx_rdy: got %b exp 1", bus.m_rx_rdy_o); end
        tick();
        bus.m_rx_vld_i = 1'b0;
        #1;
        n_chk++;
        if ({bus.m_tx_vld_o, bus.req_tx_rdy_o} !== 3'b101) begin n_fail++; $display("FAIL pend_fifth_open: got %b exp 101", {bus.m_tx_vld_o, bus.req_tx_rdy_o}); end
        tick();
        n_chk++;
        if (bus.m_tx_vld_o !== 1'b0) begin n_fail++; $display("FAIL pend_full_again: got %b exp 0", bus.m_tx_vld_o); end
    endtask
    task automatic test_drain();
        do_reset();
        bus.req_tx_vld_i = 2'b01;
        bus.m_tx_rdy_i   = 1'b1;
        tick();
        tick();
        tick();
        bus.m_tx_rdy_i   = 1'b0;
        bus.eot_i        = 1'b1;
        bus.req_tx_vld_i = 2'b11;
        tick();
        bus.m_tx_rdy_i = 1'b1;
        bus.m_rx_vld_i = 1'b1;
        #1;
        n_chk++;
        if ({bus.busy_o, bus.grant_o} !== 3'b101) begin n_fail++; $display("FAIL drain_state: got %b exp 101", {bus.busy_o, bus.grant_o}); end
        n_chk++;
        if ({bus.m_tx_vld_o, bus.req_tx_rdy_o} !== 3'b000) begin n_fail++; $display("FAIL drain_tx_blocked: got %b exp 000", {bus.m_tx_vld_o, bus.req_tx_rdy_o}); end
        n_chk++;
        if (bus.req_rx_vld_o !== 2'b01) begin n_fail++; $display("FAIL drain_rx_route: got %b exp 01", bus.req_rx_vld_o); end
        tick();
        bus.eot_i = 1'b0;
        n_chk++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL drain_hold: got %b exp 01", bus.grant_o); end
        tick();
        bus.m_rx_vld_i = 1'b0;
        n_chk++;
        if ({bus.busy_o, bus.grant_o} !== 3'b000) begin n_fail++; $display("FAIL drain_to_idle: got %b exp 000", {bus.busy_o, bus.grant_o}); end
        tick();
        n_chk++;
        if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL drain_next_grant: got %b exp 10", bus.grant_o); end
    endtask
    task automatic test_same_cycle_and_err();
        do_reset();
        bus.req_tx_vld_i = 2'b01;
        bus.m_tx_rdy_i   = 1'b1;
        tick();
        tick();
        bus.m_rx_vld_i = 1'b1;
        bus.eot_i      = 1'b1;
        #1;
        n_chk++;
        if ({bus.m_tx_vld_o, bus.m_rx_rdy_o} !== 2'b11) begin n_fail++; $display("FAIL same_both_hs: got %b exp 11", {bus.m_tx_vld_o, bus.m_rx_rdy_o}); end
        tick();
        bus.eot_i      = 1'b0;
        bus.m_tx_rdy_i = 1'b0;
        n_chk++;
        if ({bus.busy_o, bus.grant_o, bus.m_tx_vld_o} !== 4'b1010) begin n_fail++; $display("FAIL same_drain: got %b exp 1010", {bus.busy_o, bus.grant_o, bus.m_tx_vld_o}); end
        tick();
        bus.req_tx_vld_i = 2'b00;
        bus.m_rx_vld_i   = 1'b0;
        n_chk++;
        if ({bus.busy_o, bus.grant_o, bus.err_o} !== 4'b0000) begin n_fail++; $display("FAIL same_idle: got %b exp 0000", {bus.busy_o, bus.grant_o, bus.err_o}); end
        bus.req_tx_vld_i = 2'b01;
        tick();
        bus.req_tx_vld_i = 2'b00;
        bus.m_rx_vld_i   = 1'b1;
        tick();
        bus.m_rx_vld_i = 1'b0;
        n_chk++;
        if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b exp 1", bus.err_o); end
        bus.eot_i = 1'b1;
        tick();
        bus.eot_i = 1'b0;
        n_chk++;
        if ({bus.busy_o, bus.err_o} !== 2'b01) begin n_fail++; $display("FAIL err_no_underflow: got %b exp 01", {bus.busy_o, bus.err_o}); end
    endtask
    task automatic test_async_reset();
        logic [8:0] obs;
        do_reset();
        bus.req_tx_vld_i = 2'b10;
        bus.m_tx_rdy_i   = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus.m_tx_rdy_i = 1'b0;
        bus.m_rx_vld_i = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        obs = {bus.grant_o, bus.busy_o, bus.m_tx_vld_o, bus.req_tx_rdy_o, bus.m_rx_rdy_o, bus.req_rx_vld_o};
        n_chk++;
        if (obs !== 9'b0) begin n_fail++; $display("FAIL async_reset_outputs: got %b exp %b", obs, 9'b0); end
        #1;
        bus.m_rx_vld_i   = 1'b0;
        bus.req_tx_vld_i = 2'b11;
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL async_first_grant: got %b exp 01", bus.grant_o); end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_max_pend();
        test_drain();
        test_same_cycle_and_err();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
